lfsr_rng: RTL and testbench

Parametrised Galois-LFSR random number generator for game logic such as ghost direction and fruit placement.
- Seeds from a free-running entropy counter at a player-timed event.
- Serves requests through a ready/valid handshake.
- Returns uniform values in [0, RANGE-1] using bounded rejection sampling.

---
 rtl/rng_pkg.sv | 16 +
 rtl/lfsr_core.sv | 30 +++
 rtl/lfsr_rng.sv | 140 ++++++++++++++
 tb/tb_lfsr_rng.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and default constants for the LFSR random number generator.
package rng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  // Maximal-length Galois feedback masks per common width.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  localparam logic [15:0] SEED_16 = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with step/load/hold control; zero loads fall back to SEED.
module lfsr_core #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr,
  output logic [WIDTH-1:0] lfsr_next
);

  // Right-shift Galois step.
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  // Load has priority over step; the register never holds zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Uniform random values in [0, RANGE-1] via bounded rejection sampling.
// Optional: define RNG_STATS_EN to add the reject_cnt statistics port.
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_16),
  parameter int unsigned      RANGE     = 3,
  parameter int unsigned      MAX_TRIES = 4,
  localparam int unsigned     OUT_W     = ($clog2(RANGE) < 1) ? 1 : $clog2(RANGE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic             free_run,
  input  logic             req,
  output logic             ready,
  output logic [OUT_W-1:0] rand_val,
  output logic             rand_valid
`ifdef RNG_STATS_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int unsigned    TRY_W   = ($clog2(MAX_TRIES) < 1) ? 1 : $clog2(MAX_TRIES);
  localparam logic [OUT_W:0] RANGE_W = (OUT_W+1)'(RANGE);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   ent_cnt;
  logic [TRY_W-1:0]   try_cnt, try_nxt;
  logic               seed_pend, pend_nxt;
  logic [OUT_W-1:0]   val_nxt;
  logic               valid_nxt;
  logic               step, load, rej_inc;
  logic [WIDTH-1:0]   lfsr, lfsr_next;
  logic [OUT_W-1:0]   cand;
  logic               unused_lfsr;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (step),
    .load      (load),
    .load_val  (ent_cnt ^ SEED),
    .lfsr      (lfsr),
    .lfsr_next (lfsr_next)
  );

  assign cand        = lfsr_next[OUT_W-1:0];
  assign ready       = (state == IDLE);
  assign unused_lfsr = ^{lfsr, lfsr_next};

  // Free-running entropy counter sampled by reseeds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ent_cnt <= '0;
    else          ent_cnt <= ent_cnt + WIDTH'(1);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      try_cnt    <= '0;
      seed_pend  <= 1'b0;
      rand_val   <= '0;
      rand_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      try_cnt    <= try_nxt;
      seed_pend  <= pend_nxt;
      rand_val   <= val_nxt;
      rand_valid <= valid_nxt;
    end
  end

  // Next-state, LFSR control and rejection sampling.
  always_comb begin
    state_nxt = state;
    try_nxt   = try_cnt;
    pend_nxt  = seed_pend;
    val_nxt   = rand_val;
    valid_nxt = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    rej_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load) load = 1'b1;
        if (req) begin
          state_nxt = GEN;
          try_nxt   = '0;
        end else if (free_run && !seed_load) begin
          step = 1'b1;
        end
      end
      GEN: begin
        step = 1'b1;
        if (seed_load) pend_nxt = 1'b1;
        if ({1'b0, cand} < RANGE_W) begin
          val_nxt   = cand;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (try_cnt == TRY_LAST) begin
          val_nxt   = OUT_W'({1'b0, cand} - RANGE_W);
          valid_nxt = 1'b1;
          state_nxt = IDLE;
          rej_inc   = 1'b1;
        end else begin
          try_nxt = try_cnt + TRY_W'(1);
          rej_inc = 1'b1;
        end
        // A pending reseed overrides this edge's step on the way back to IDLE.
        if (state_nxt == IDLE) begin
          if (seed_pend || seed_load) load = 1'b1;
          pend_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RNG_STATS_EN
  // Saturating count of rejected candidates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               reject_cnt <= '0;
    else if (rej_inc && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
  end
`else
  logic unused_rej;
  assign unused_rej = rej_inc;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: default, MAX_TRIES=2 and SEED=5 builds.
module tb_lfsr_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default and MAX_TRIES=2 instances share stimulus.
  logic       a_rst_n, a_seed, a_free, a_req;
  logic       a_ready, a_valid, m_ready, m_valid;
  logic [1:0] a_val, m_val;
  // SEED=5 instance.
  logic       s_rst_n, s_seed, s_free, s_req;
  logic       s_ready, s_valid;
  logic [1:0] s_val;
`ifdef RNG_STATS_EN
  logic [15:0] a_rej, m_rej, s_rej;
`endif

  lfsr_rng dut_a (
    .clk(clk), .reset_n(a_rst_n), .seed_load(a_seed), .free_run(a_free), .req(a_req),
    .ready(a_ready), .rand_val(a_val), .rand_valid(a_valid)
`ifdef RNG_STATS_EN
    , .reject_cnt(a_rej)
`endif
  );

  lfsr_rng #(.MAX_TRIES(2)) dut_m (
    .clk(clk), .reset_n(a_rst_n), .seed_load(a_seed), .free_run(a_free), .req(a_req),
    .ready(m_ready), .rand_val(m_val), .rand_valid(m_valid)
`ifdef RNG_STATS_EN
    , .reject_cnt(m_rej)
`endif
  );

  lfsr_rng #(.SEED(16'h0005)) dut_s (
    .clk(clk), .reset_n(s_rst_n), .seed_load(s_seed), .free_run(s_free), .req(s_req),
    .ready(s_ready), .rand_val(s_val), .rand_valid(s_valid)
`ifdef RNG_STATS_EN
    , .reject_cnt(s_rej)
`endif
  );

  logic [1:0] qa[$], qm[$], qs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result pulse pops the value expected at request time.
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else                check("a_rand_val", 32'(a_val), 32'(qa.pop_front()));
    end
    if (m_valid) begin
      if (qm.size() == 0) check("m_unexpected_valid", 32'd1, 32'd0);
      else                check("m_rand_val", 32'(m_val), 32'(qm.pop_front()));
    end
    if (s_valid) begin
      if (qs.size() == 0) check("s_unexpected_valid", 32'd1, 32'd0);
      else                check("s_rand_val", 32'(s_val), 32'(qs.pop_front()));
    end
  end

  task automatic reset_a();
    @(negedge clk);
    a_rst_n = 1'b0;
    qa.delete();
    qm.delete();
    @(negedge clk);
    a_rst_n = 1'b1;
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_val", 32'(a_val), 32'd0);
    check("rst_lfsr", 32'(dut_a.lfsr), 32'hACE1);
  endtask

  // Issue one request to dut_a/dut_m and check latency, ready and final LFSR.
  task automatic req_ab(input logic [1:0] ea, input int la, input logic [1:0] em, input int lm,
                        input logic [15:0] lfsr_a);
    int got_a, got_m, low;
    check("pre_req_ready", 32'(a_ready), 32'd1);
    qa.push_back(ea);
    qm.push_back(em);
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    got_a = 0;
    got_m = 0;
    low = a_ready ? 0 : 1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (got_a == 0 && a_valid) got_a = cyc;
      if (got_m == 0 && m_valid) got_m = cyc;
      if (got_a == 0 && !a_ready) low++;
      if (got_a != 0 && got_m != 0) break;
    end
    check("lat_a", 32'(got_a), 32'(la));
    check("lat_m", 32'(got_m), 32'(lm));
    check("ready_low_cycles", 32'(low), 32'(la));
    check("ready_at_valid", 32'(a_ready), 32'd1);
    check("lfsr_a", 32'(dut_a.lfsr), 32'(lfsr_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    a_rst_n = 1'b0; a_seed = 1'b0; a_free = 1'b0; a_req = 1'b0;
    s_rst_n = 1'b0; s_seed = 1'b0; s_free = 1'b0; s_req = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back requests, then a multi-attempt request / fallback.
    reset_a();
    req_ab(2'd0, 1, 2'd0, 1, 16'hE270);
    req_ab(2'd0, 1, 2'd0, 1, 16'h7138);
    req_ab(2'd0, 1, 2'd0, 1, 16'h389C);
    req_ab(2'd2, 1, 2'd2, 1, 16'h1C4E);
    req_ab(2'd1, 3, 2'd0, 2, 16'hED89);
`ifdef RNG_STATS_EN
    check("reject_cnt_a", 32'(a_rej), 32'd2);
    check("reject_cnt_m", 32'(m_rej), 32'd2);
`endif

    // Async reset in the middle of the 5th request.
    reset_a();
    req_ab(2'd0, 1, 2'd0, 1, 16'hE270);
    req_ab(2'd0, 1, 2'd0, 1, 16'h7138);
    req_ab(2'd0, 1, 2'd0, 1, 16'h389C);
    req_ab(2'd2, 1, 2'd2, 1, 16'h1C4E);
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    check("mid_gen_ready", 32'(a_ready), 32'd0);
    #2 a_rst_n = 1'b0;
    #1;
    check("async_valid", 32'(a_valid), 32'd0);
    check("async_ready", 32'(a_ready), 32'd1);
    check("async_lfsr", 32'(dut_a.lfsr), 32'hACE1);
    check("async_lfsr_m", 32'(dut_m.lfsr), 32'hACE1);
    qa.delete();
    qm.delete();
    @(negedge clk);
    a_rst_n = 1'b1;
    req_ab(2'd0, 1, 2'd0, 1, 16'hE270);

    // Free-running steps in IDLE before a request.
    reset_a();
    a_free = 1'b1;
    repeat (3) @(negedge clk);
    a_free = 1'b0;
    check("free_run_lfsr", 32'(dut_a.lfsr), 32'h389C);
    req_ab(2'd2, 1, 2'd2, 1, 16'h1C4E);

    // SEED=5: reseed at ent_cnt=0xA, then reseed during GEN.
    @(negedge clk);
    s_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    s_seed = 1'b1;
    @(negedge clk);
    s_seed = 1'b0;
    check("seed_lfsr", 32'(dut_s.lfsr), 32'h000F);
    qs.push_back(2'd1);
    s_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    s_seed = 1'b1;
    got = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      s_seed = 1'b0;
      if (s_valid) begin
        got = cyc;
        break;
      end
    end
    check("s_lat", 32'(got), 32'd3);
    check("gen_seed_lfsr", 32'(dut_s.lfsr), 32'h000B);
    check("s_ready_after", 32'(s_ready), 32'd1);

    // SEED=5: reseed at ent_cnt=5 hits the zero guard.
    s_rst_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    s_seed = 1'b1;
    @(negedge clk);
    s_seed = 1'b0;
    check("zero_guard_lfsr", 32'(dut_s.lfsr), 32'h0005);

    repeat (2) @(negedge clk);
    check("queues_drained", 32'(qa.size() + qm.size() + qs.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
